// File: rtl/button_pulse_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_pulse_pkg;

   // Per-channel conditioner state.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE   = 2'd1,
      LOCKOUT = 2'd2,
      HOLD    = 2'd3
   } state_e;

   // Counter width large enough to reach the longer of lockout and repeat.
   function automatic int cnt_width(input int lockout, input int rpt);
      int m;
      m = (lockout > rpt) ? lockout : rpt;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_pulse_channel.sv
// One button channel: synchroniser, armed flag, pulse/lockout FSM and counter.
module button_pulse_channel
   import button_pulse_pkg::*;
#(
   parameter int PULSE_CYCLES   = 16,
   parameter int LOCKOUT_CYCLES = 33554432,
   parameter int REPEAT_CYCLES  = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic pulse_n,
   output logic press,
   output logic busy
);

   localparam int CNT_W = cnt_width(LOCKOUT_CYCLES, REPEAT_CYCLES);
   localparam bit REPEAT_EN = (REPEAT_CYCLES > 0);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_EN ? REPEAT_CYCLES - 1 : 0);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [1:0]       vld_q, vld_d;
   logic             armed_q, armed_d;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_n_q, pulse_n_d;
   logic             press_q, press_d;
   logic             busy_q, busy_d;
   logic             held;
   logic             released;

   // Next-state logic: synchroniser shift, arming, FSM and registered outputs.
   always_comb begin
      sync1_d  = btn_n;
      sync2_d  = sync1_q;
      // vld_q tracks when sync2_q holds a real post-reset sample rather than
      // its reset value, so a button held through reset is never seen as a
      // release that would arm the channel.
      vld_d    = {vld_q[0], 1'b1};
      held     = vld_q[1] & ~sync2_q;
      released = vld_q[1] & sync2_q;
      armed_d  = armed_q | released;
      state_d  = state_q;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (held) begin
               state_d = armed_q ? PULSE : HOLD;
            end
         end
         PULSE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == PULSE_LAST) begin
               state_d = LOCKOUT;
            end
         end
         LOCKOUT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LOCK_LAST) begin
               if (sync2_q) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = HOLD;
                  cnt_d   = REPEAT_EN ? '0 : cnt_q;
               end
            end
         end
         HOLD: begin
            if (sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (REPEAT_EN && armed_q) begin
               // Only an armed channel may auto-repeat; a button held through
               // reset sits here with the counter frozen until released.
               if (cnt_q == REP_LAST) begin
                  state_d = PULSE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      pulse_n_d = (state_d != PULSE);
      press_d   = (state_d == PULSE) && (state_q != PULSE);
      busy_d    = (state_d != IDLE);
   end

   // State registers with synchronous reset to the released/idle condition.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         vld_q     <= 2'b00;
         armed_q   <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         pulse_n_q <= 1'b1;
         press_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         vld_q     <= vld_d;
         armed_q   <= armed_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pulse_n_q <= pulse_n_d;
         press_q   <= press_d;
         busy_q    <= busy_d;
      end
   end

   assign pulse_n = pulse_n_q;
   assign press   = press_q;
   assign busy    = busy_q;

endmodule

// File: rtl/button_pulse_array.sv
// Array of independent push-button conditioners sharing one clock and reset.
module button_pulse_array
   import button_pulse_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int PULSE_CYCLES   = 16,
   parameter int LOCKOUT_CYCLES = 33554432,
   parameter int REPEAT_CYCLES  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn_n,
   output logic [CHANNELS-1:0] pulse_n,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] busy
);

   localparam int CNT_W = cnt_width(LOCKOUT_CYCLES, REPEAT_CYCLES);

   if (CHANNELS < 1) begin : g_bad_channels
      $error("button_pulse_array: CHANNELS must be at least 1");
   end
   if (PULSE_CYCLES < 1) begin : g_bad_pulse
      $error("button_pulse_array: PULSE_CYCLES must be at least 1");
   end
   if (LOCKOUT_CYCLES <= PULSE_CYCLES) begin : g_bad_lockout
      $error("button_pulse_array: LOCKOUT_CYCLES must exceed PULSE_CYCLES");
   end
   if (REPEAT_CYCLES < 0) begin : g_bad_repeat
      $error("button_pulse_array: REPEAT_CYCLES must not be negative");
   end
   if (CNT_W > 31) begin : g_bad_width
      $error("button_pulse_array: counter width too large");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      button_pulse_channel #(
         .PULSE_CYCLES   (PULSE_CYCLES),
         .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
         .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .btn_n   (btn_n[i]),
         .pulse_n (pulse_n[i]),
         .press   (press[i]),
         .busy    (busy[i])
      );
   end

endmodule

// File: doc/button_pulse_array.md
# button_pulse_array

Parametrised multi-channel button conditioner for the board's push-buttons, feeding the CPU's manual-clock, step and input-confirm logic. Each active-low raw button is synchronised and converted into one registered active-low pulse of fixed length, followed by a lockout window that masks contact bounce. Optional auto-repeat re-fires the pulse while the button stays held. Channels are fully independent.

## Interface
- CHANNELS, 4: number of independent button channels (≥1).
- PULSE_CYCLES, 16: pulse_n low time in clk cycles (≥1).
- LOCKOUT_CYCLES, 33554432: cycles from pulse start until the channel can re-arm (> PULSE_CYCLES).
- REPEAT_CYCLES, 0: auto-repeat period while held, measured from lockout end; 0 disables auto-repeat.
- CNT_W, derived: $clog2(max(LOCKOUT_CYCLES, REPEAT_CYCLES)+1); not overridden.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_n  in  CHANNELS  raw asynchronous buttons, 0 = pressed.
- pulse_n  out  CHANNELS  conditioned pulse, 0 = active, registered.
- press  out  CHANNELS  1-cycle active-high strobe on each pulse start, registered.
- busy  out  CHANNELS  1 while channel is not IDLE, registered.

## Operation
- Per channel: 2-flop synchroniser (reset value 1 = released), then FSM plus CNT_W-bit counter.
- States: IDLE, PULSE, LOCKOUT, HOLD.
- IDLE: counter held at 0. Synchronised press → PULSE, counter := 0, press strobe set.
- PULSE: counter increments each cycle; pulse_n low. At counter == PULSE_CYCLES-1 → LOCKOUT, counter keeps counting.
- LOCKOUT: pulse_n high, presses ignored. At counter == LOCKOUT_CYCLES-1: released → IDLE; held and REPEAT_CYCLES == 0 → HOLD; held and REPEAT_CYCLES > 0 → HOLD, counter := 0.
- HOLD: released → IDLE. With REPEAT_CYCLES > 0: counter increments; at counter == REPEAT_CYCLES-1 while still held → PULSE, counter := 0, press strobe. With REPEAT_CYCLES == 0: counter frozen; only release exits.
- A press is never re-armed without passing through IDLE unless auto-repeat fires.
- Release during PULSE or LOCKOUT does not shorten either window.
- Counter never wraps: every state exits at or before its terminal count.
- Reset (any time, including mid-pulse): all channels → IDLE, counter 0, pulse_n all 1, press all 0, busy all 0, synchronisers all 1. No pulse is emitted for a button held through reset until it is released and pressed again: after reset a channel enters HOLD instead of PULSE if the synchronised input reads pressed on the first post-reset sample. Implement this with a per-channel armed flag that is cleared by reset and set on the first released sample.

## Timing
- Press latency: btn_n low set up before edge k. Synchronised at edge k+1. FSM in PULSE with pulse_n = 0, press = 1, busy = 1 after edge k+2.
- pulse_n is low for exactly PULSE_CYCLES cycles.
- press is high for exactly 1 cycle per pulse.
- Earliest re-arm: IDLE entered LOCKOUT_CYCLES cycles after pulse start, provided the button is released by then. Otherwise IDLE is entered 1 cycle after the synchronised release is seen.
- Auto-repeat pulse starts are spaced LOCKOUT_CYCLES + REPEAT_CYCLES cycles apart. The first spacing is the same.
- Channels sharing a clock edge act independently; simultaneous presses each produce their own pulse.

## Structure
- Package button_pulse_pkg: state enum (IDLE, PULSE, LOCKOUT, HOLD) and a count-width helper function.
- Sub-module button_pulse_channel: synchroniser, armed flag, FSM and counter for one channel.
- Top level: generate loop of CHANNELS instances; parameter legality checks via elaboration-time assertions.

## Test plan
Bench parameters: CHANNELS=2, PULSE_CYCLES=4, LOCKOUT_CYCLES=20, REPEAT_CYCLES=0 unless stated.
- Reset values: assert rst for 3 cycles with btn_n=2'b11 → pulse_n=2'b11, press=0, busy=0 throughout and after.
- Single press: btn_n[0] low before edge k, held for 2 cycles, then released → pulse_n[0] low after edges k+2..k+5 (4 cycles); press[0] high 1 cycle after edge k+2; busy[0] falls 20 cycles after pulse start; channel 1 stays idle.
- Bounce: btn_n[0] toggles every cycle for 15 cycles → exactly one pulse and one press strobe.
- Held button, no repeat: btn_n[1] held 60 cycles → one pulse; channel in HOLD until release; a new press 5 cycles after release gives a second pulse.
- Auto-repeat, REPEAT_CYCLES=8: btn_n[0] held 100 cycles → pulse starts at t0, t0+28, t0+56, t0+84.
- Reset mid-pulse: rst asserted at the 2nd pulse cycle with button held → pulse_n=1 after the reset edge; no pulse until release and re-press. Simultaneous press on both channels → both pulse on the same cycle.
